// File: rtl/frv_pipeline_writeback_pkg.sv
// frv writeback stage: shared field positions, encodings and state type.
// Imported by the writeback stage and its load alignment helper.
package frv_pipeline_writeback_pkg;

    localparam int P_FU_ALU = 0;
    localparam int P_FU_MUL = 1;
    localparam int P_FU_CFU = 2;
    localparam int P_FU_LSU = 3;
    localparam int P_FU_CSR = 4;

    localparam int LSU_SIGNED = 0;
    localparam int LSU_LOAD   = 3;
    localparam int LSU_STORE  = 4;

    localparam logic [1:0] LSU_BYTE = 2'b01;
    localparam logic [1:0] LSU_HALF = 2'b10;
    localparam logic [1:0] LSU_WORD = 2'b11;

    typedef enum logic {
        WB_IDLE,
        WB_DRAIN
    } wb_state_t;

    function automatic logic [1:0] lsu_size(input logic [4:0] uop);
        return uop[2:1];
    endfunction

endpackage

// File: rtl/frv_load_align.sv
// Load data alignment: shift a word-aligned response down to the
// addressed byte lane, then zero/sign-extend bytes and halfwords.
module frv_load_align
    import frv_pipeline_writeback_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      offset,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    assign shifted = data >> {offset, 3'b000};

    always_comb begin
        result = shifted;
        unique case (size)
            LSU_BYTE: result = {{(XLEN-8){sign_ext & shifted[7]}},
                                shifted[7:0]};
            LSU_HALF: result = {{(XLEN-16){sign_ext & shifted[15]}},
                                shifted[15:0]};
            default:  result = shifted;
        endcase
    end

endmodule

// File: rtl/frv_pipeline_writeback.sv
// frv writeback stage: collects LSU responses, retires to the GPRs and
// raises bus-error traps; keeps at most one data response outstanding.
module frv_pipeline_writeback
    import frv_pipeline_writeback_pkg::*;
#(
    parameter int         XLEN          = 32,
    parameter logic [5:0] TRAP_LDACCESS = 6'd5,
    parameter logic [5:0] TRAP_STACCESS = 6'd7
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            flush,
    input  logic [4:0]      s4_rd,
    input  logic [XLEN-1:0] s4_opr_a,
    input  logic [XLEN-1:0] s4_opr_b,
    input  logic [4:0]      s4_uop,
    input  logic [4:0]      s4_fu,
    input  logic            s4_trap,
    input  logic [1:0]      s4_size,
    input  logic [31:0]     s4_instr,
    input  logic            s4_valid,
    output logic            s4_busy,
    input  logic            dmem_recv,
    input  logic            dmem_error,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic [XLEN-1:0] mmio_rdata,
    input  logic            mmio_error,
    output logic            hold_lsu_req,
    output logic            gpr_wen,
    output logic [4:0]      gpr_rd,
    output logic [XLEN-1:0] gpr_wdata,
    output logic [4:0]      fwd_s4_rd,
    output logic [XLEN-1:0] fwd_s4_wdata,
    output logic            fwd_s4_load,
    output logic            trap_cpu,
    output logic [5:0]      trap_cause,
    output logic            instr_ret
);

    localparam int XL = XLEN - 1;

    wb_state_t state;
    wb_state_t state_nxt;

    logic          lsu;
    logic          mmio;
    logic          need_rsp;
    logic          load;
    logic          idle;
    logic          retire;
    logic          err;
    logic [XL:0]   ld_src;
    logic [XL:0]   ld_data;
    logic          unused_ok;

    assign lsu      = s4_fu[P_FU_LSU] && !s4_trap;
    assign mmio     = s4_opr_a[4];
    assign need_rsp = lsu && !mmio;
    assign load     = lsu && s4_uop[LSU_LOAD];
    assign idle     = (state == WB_IDLE);
    assign ld_src   = mmio ? mmio_rdata : dmem_rdata;

    assign unused_ok = ^{s4_opr_b[XL:2], s4_size, s4_instr,
                         s4_uop[LSU_STORE], s4_fu};

    frv_load_align #(
        .XLEN(XLEN)
    ) u_align (
        .data    (ld_src),
        .offset  (s4_opr_b[1:0]),
        .size    (lsu_size(s4_uop)),
        .sign_ext(s4_uop[LSU_SIGNED]),
        .result  (ld_data)
    );

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state <= WB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A flushed request that was already granted still owes a response.
    always_comb begin
        state_nxt = state;
        unique case (state)
            WB_IDLE: begin
                if (flush && s4_valid && need_rsp && !dmem_recv) begin
                    state_nxt = WB_DRAIN;
                end
            end
            WB_DRAIN: begin
                if (dmem_recv) begin
                    state_nxt = WB_IDLE;
                end
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    always_comb begin
        retire = s4_valid && !flush && idle &&
                 (!need_rsp || dmem_recv);
        err    = lsu && (mmio ? mmio_error : (dmem_error && dmem_recv));

        s4_busy      = s4_valid && !retire;
        hold_lsu_req = (s4_valid && need_rsp && !dmem_recv) || !idle;
        instr_ret    = retire;
        trap_cpu     = retire && (s4_trap || err);
        gpr_wen      = retire && !err && !s4_trap &&
                       (s4_rd != 5'd0) && (!lsu || load);

        trap_cause = 6'd0;
        if (trap_cpu) begin
            trap_cause = s4_trap ? {1'b0, s4_rd} :
                         load    ? TRAP_LDACCESS : TRAP_STACCESS;
        end

        gpr_rd    = s4_valid ? s4_rd : 5'd0;
        gpr_wdata = '0;
        if (s4_valid) begin
            gpr_wdata = load ? ld_data : s4_opr_a;
        end

        fwd_s4_rd    = gpr_rd;
        fwd_s4_wdata = gpr_wdata;
        fwd_s4_load  = s4_valid && load && !retire;
    end

endmodule

// File: tb/tb_frv_pipeline_writeback.sv
// Directed bench for frv_pipeline_writeback: single-cycle vector
// table plus multi-cycle sequences for stalls, drain and reset.
module tb_frv_pipeline_writeback;

    typedef struct packed {
        logic        valid;
        logic        flush;
        logic [4:0]  rd;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [4:0]  uop;
        logic [4:0]  fu;
        logic        trap;
        logic        recv;
        logic        derr;
        logic [31:0] rdata;
        logic [31:0] mrdata;
        logic        merr;
    } vin_t;

    typedef struct packed {
        logic        busy;
        logic        hold;
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        trap;
        logic [5:0]  cause;
        logic        ret;
        logic        fld;
    } vexp_t;

    typedef struct packed {
        vin_t  i;
        vexp_t e;
    } vec_t;

    localparam logic [4:0] FU_ALU = 5'b00001;
    localparam logic [4:0] FU_LSU = 5'b01000;
    localparam logic [4:0] LD_BS  = 5'd11;
    localparam logic [4:0] LD_BU  = 5'd10;
    localparam logic [4:0] LD_HU  = 5'd12;
    localparam logic [4:0] LD_HS  = 5'd13;
    localparam logic [4:0] LD_W   = 5'd14;
    localparam logic [4:0] ST_W   = 5'd22;
    localparam int NV = 15;

    logic        g_clk;
    logic        g_resetn;
    logic        flush;
    logic [4:0]  s4_rd;
    logic [31:0] s4_opr_a;
    logic [31:0] s4_opr_b;
    logic [4:0]  s4_uop;
    logic [4:0]  s4_fu;
    logic        s4_trap;
    logic [1:0]  s4_size;
    logic [31:0] s4_instr;
    logic        s4_valid;
    logic        s4_busy;
    logic        dmem_recv;
    logic        dmem_error;
    logic [31:0] dmem_rdata;
    logic [31:0] mmio_rdata;
    logic        mmio_error;
    logic        hold_lsu_req;
    logic        gpr_wen;
    logic [4:0]  gpr_rd;
    logic [31:0] gpr_wdata;
    logic [4:0]  fwd_s4_rd;
    logic [31:0] fwd_s4_wdata;
    logic        fwd_s4_load;
    logic        trap_cpu;
    logic [5:0]  trap_cause;
    logic        instr_ret;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t  vecs [NV];
    string names[NV];

    frv_pipeline_writeback dut (
        .g_clk       (g_clk),
        .g_resetn    (g_resetn),
        .flush       (flush),
        .s4_rd       (s4_rd),
        .s4_opr_a    (s4_opr_a),
        .s4_opr_b    (s4_opr_b),
        .s4_uop      (s4_uop),
        .s4_fu       (s4_fu),
        .s4_trap     (s4_trap),
        .s4_size     (s4_size),
        .s4_instr    (s4_instr),
        .s4_valid    (s4_valid),
        .s4_busy     (s4_busy),
        .dmem_recv   (dmem_recv),
        .dmem_error  (dmem_error),
        .dmem_rdata  (dmem_rdata),
        .mmio_rdata  (mmio_rdata),
        .mmio_error  (mmio_error),
        .hold_lsu_req(hold_lsu_req),
        .gpr_wen     (gpr_wen),
        .gpr_rd      (gpr_rd),
        .gpr_wdata   (gpr_wdata),
        .fwd_s4_rd   (fwd_s4_rd),
        .fwd_s4_wdata(fwd_s4_wdata),
        .fwd_s4_load (fwd_s4_load),
        .trap_cpu    (trap_cpu),
        .trap_cause  (trap_cause),
        .instr_ret   (instr_ret)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    function automatic vin_t vi(
        input logic v, input logic fl, input logic [4:0] rd,
        input logic [31:0] a, input logic [31:0] b,
        input logic [4:0] u, input logic [4:0] f, input logic t,
        input logic rc, input logic de, input logic [31:0] rdat,
        input logic [31:0] mdat, input logic me);
        vin_t x;
        x.valid = v;   x.flush = fl; x.rd = rd;
        x.opa = a;     x.opb = b;    x.uop = u;
        x.fu = f;      x.trap = t;   x.recv = rc;
        x.derr = de;   x.rdata = rdat;
        x.mrdata = mdat; x.merr = me;
        return x;
    endfunction

    function automatic vexp_t ve(
        input logic bz, input logic hd, input logic we,
        input logic [4:0] rd, input logic [31:0] wd,
        input logic tr, input logic [5:0] ca,
        input logic rt, input logic fl);
        vexp_t x;
        x.busy = bz; x.hold = hd; x.wen = we;
        x.rd = rd;   x.wdata = wd; x.trap = tr;
        x.cause = ca; x.ret = rt;  x.fld = fl;
        return x;
    endfunction

    task automatic drive(input vin_t v);
        s4_valid   = v.valid;
        flush      = v.flush;
        s4_rd      = v.rd;
        s4_opr_a   = v.opa;
        s4_opr_b   = v.opb;
        s4_uop     = v.uop;
        s4_fu      = v.fu;
        s4_trap    = v.trap;
        dmem_recv  = v.recv;
        dmem_error = v.derr;
        dmem_rdata = v.rdata;
        mmio_rdata = v.mrdata;
        mmio_error = v.merr;
    endtask

    task automatic chk(input string n, input string f,
                       input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s.%s got=%h exp=%h", n, f, got, exp);
        end
    endtask

    task automatic check(input string n, input vexp_t e);
        chk(n, "busy",      {31'd0, s4_busy},      {31'd0, e.busy});
        chk(n, "hold",      {31'd0, hold_lsu_req}, {31'd0, e.hold});
        chk(n, "wen",       {31'd0, gpr_wen},      {31'd0, e.wen});
        chk(n, "rd",        {27'd0, gpr_rd},       {27'd0, e.rd});
        chk(n, "wdata",     gpr_wdata,             e.wdata);
        chk(n, "fwd_rd",    {27'd0, fwd_s4_rd},    {27'd0, e.rd});
        chk(n, "fwd_wdata", fwd_s4_wdata,          e.wdata);
        chk(n, "fwd_load",  {31'd0, fwd_s4_load},  {31'd0, e.fld});
        chk(n, "trap",      {31'd0, trap_cpu},     {31'd0, e.trap});
        chk(n, "cause",     {26'd0, trap_cause},   {26'd0, e.cause});
        chk(n, "ret",       {31'd0, instr_ret},    {31'd0, e.ret});
    endtask

    task automatic step_check(input string n, input vin_t v,
                              input vexp_t e);
        @(negedge g_clk);
        drive(v);
        #1;
        check(n, e);
    endtask

    vin_t  idle_in;
    vexp_t zero_e;

    initial begin
        s4_size  = 2'b10;
        s4_instr = 32'h0000_0013;
        idle_in  = vi(0,0,0,0,0,0,0,0,0,0,0,0,0);
        zero_e   = ve(0,0,0,0,0,0,0,0,0);

        names[0]  = "alu";
        vecs[0]   = '{vi(1,0,5,32'h1234,0,0,FU_ALU,0,0,0,0,0,0),
                      ve(0,0,1,5,32'h1234,0,0,1,0)};
        names[1]  = "ld_hu";
        vecs[1]   = '{vi(1,0,7,32'hC,32'h2,LD_HU,FU_LSU,0,1,0,
                         32'hBEEF0000,0,0),
                      ve(0,0,1,7,32'h0000BEEF,0,0,1,0)};
        names[2]  = "ld_hs";
        vecs[2]   = '{vi(1,0,7,32'hC,32'h2,LD_HS,FU_LSU,0,1,0,
                         32'hBEEF0000,0,0),
                      ve(0,0,1,7,32'hFFFFBEEF,0,0,1,0)};
        names[3]  = "ld_bs_now";
        vecs[3]   = '{vi(1,0,6,32'h8,32'h103,LD_BS,FU_LSU,0,1,0,
                         32'h80FFFFFF,0,0),
                      ve(0,0,1,6,32'hFFFFFF80,0,0,1,0)};
        names[4]  = "ld_bu";
        vecs[4]   = '{vi(1,0,10,32'h2,32'h1,LD_BU,FU_LSU,0,1,0,
                         32'h00009A00,0,0),
                      ve(0,0,1,10,32'h0000009A,0,0,1,0)};
        names[5]  = "ld_w";
        vecs[5]   = '{vi(1,0,11,32'hF,32'h40,LD_W,FU_LSU,0,1,0,
                         32'hDEADBEEF,0,0),
                      ve(0,0,1,11,32'hDEADBEEF,0,0,1,0)};
        names[6]  = "st_err";
        vecs[6]   = '{vi(1,0,3,32'hF,32'h80,ST_W,FU_LSU,0,1,1,0,0,0),
                      ve(0,0,0,3,32'hF,1,6'd7,1,0)};
        names[7]  = "ld_err";
        vecs[7]   = '{vi(1,0,8,32'hF,32'h0,LD_W,FU_LSU,0,1,1,
                         32'h11,0,0),
                      ve(0,0,0,8,32'h11,1,6'd5,1,0)};
        names[8]  = "mmio_ld_x0";
        vecs[8]   = '{vi(1,0,0,32'h1F,32'h0,LD_W,FU_LSU,0,0,0,
                         32'h12345678,32'hA5,0),
                      ve(0,0,0,0,32'hA5,0,0,1,0)};
        names[9]  = "mmio_ld_hs";
        vecs[9]   = '{vi(1,0,9,32'h1C,32'h4002,LD_HS,FU_LSU,0,0,0,
                         0,32'h80001234,0),
                      ve(0,0,1,9,32'hFFFF8000,0,0,1,0)};
        names[10] = "mmio_st_err";
        vecs[10]  = '{vi(1,0,0,32'h1F,32'h0,ST_W,FU_LSU,0,0,0,0,0,1),
                      ve(0,0,0,0,32'h1F,1,6'd7,1,0)};
        names[11] = "up_trap";
        vecs[11]  = '{vi(1,0,2,0,0,LD_W,FU_LSU,1,0,0,0,0,0),
                      ve(0,0,0,2,0,1,6'd2,1,0)};
        names[12] = "ld_pend";
        vecs[12]  = '{vi(1,0,4,32'hF,32'h0,LD_W,FU_LSU,0,0,0,0,0,0),
                      ve(1,1,0,4,0,0,0,0,1)};
        names[13] = "idle";
        vecs[13]  = '{idle_in, zero_e};
        names[14] = "alu_flush";
        vecs[14]  = '{vi(1,1,5,32'h1234,0,0,FU_ALU,0,0,0,0,0,0),
                      ve(1,0,0,5,32'h1234,0,0,0,0)};

        g_resetn = 1'b0;
        drive(idle_in);
        @(posedge g_clk);
        @(negedge g_clk);
        #1;
        check("reset", zero_e);
        g_resetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step_check(names[i], vecs[i].i, vecs[i].e);
        end

        // Byte load whose response arrives two cycles late.
        for (int c = 0; c < 2; c++) begin
            step_check("slow_ld_wait",
                vi(1,0,6,32'h1,32'h103,LD_BS,FU_LSU,0,0,0,0,0,0),
                ve(1,1,0,6,0,0,0,0,1));
        end
        step_check("slow_ld_recv",
            vi(1,0,6,32'h1,32'h103,LD_BS,FU_LSU,0,1,0,
               32'h80FFFFFF,0,0),
            ve(0,0,1,6,32'hFFFFFF80,0,0,1,0));

        // Flush a pending load, then stall an ALU op until it drains.
        step_check("drain_pend",
            vi(1,0,4,32'hF,32'h200,LD_W,FU_LSU,0,0,0,0,0,0),
            ve(1,1,0,4,0,0,0,0,1));
        step_check("drain_flush",
            vi(1,1,4,32'hF,32'h200,LD_W,FU_LSU,0,0,0,0,0,0),
            ve(1,1,0,4,0,0,0,0,1));
        step_check("drain_stall",
            vi(1,0,5,32'h1234,0,0,FU_ALU,0,0,0,0,0,0),
            ve(1,1,0,5,32'h1234,0,0,0,0));
        step_check("drain_recv",
            vi(1,0,5,32'h1234,0,0,FU_ALU,0,1,1,32'h55,0,0),
            ve(1,1,0,5,32'h1234,0,0,0,0));
        step_check("drain_done",
            vi(1,0,5,32'h1234,0,0,FU_ALU,0,0,0,0,0,0),
            ve(0,0,1,5,32'h1234,0,0,1,0));

        // Reset while draining abandons the owed response.
        step_check("rst_pend",
            vi(1,1,4,32'hF,32'h300,LD_W,FU_LSU,0,0,0,0,0,0),
            ve(1,1,0,4,0,0,0,0,1));
        step_check("rst_drain", idle_in, ve(0,1,0,0,0,0,0,0,0));
        g_resetn = 1'b0;
        @(negedge g_clk);
        g_resetn = 1'b1;
        #1;
        check("rst_after", zero_e);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
